operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//   Initiator for the register file's two read ports and its write port. Accepts decoded
//   source-register requests over a valid/ready handshake and issues the register-file reads.
//   It captures the 1-cycle-latency read data and resolves read/write hazards by forwarding
//   writeback data. It forces x0 to zero and presents both operands downstream over valid/ready.
//   It also drives the register-file write port from the writeback stage and drops x0 writes.
// PARAMETERS
//   XLEN       32   operand / register data width
//   NREG       32   architectural registers; ADDR_W = $clog2(NREG)
//   PAYLOAD_W  32   opaque sideband (pc/opcode/rd) carried alongside the operands unchanged
// PORTS
//   clk          in   1          clock, all state on posedge
//   reset        in   1          asynchronous, active-low reset
//   in_valid     in   1          request valid
//   in_ready     out  1          request accepted when in_valid && in_ready
//   in_rs1       in   ADDR_W     source register 1
//   in_rs2       in   ADDR_W     source register 2
//   in_use_rs1   in   1          rs1 needed; if 0 then op1 = 0 and no read is issued
//   in_use_rs2   in   1          rs2 needed; if 0 then op2 = 0 and no read is issued
//   in_payload   in   PAYLOAD_W  sideband
//   wb_valid     in   1          writeback request this cycle
//   wb_addr      in   ADDR_W     writeback destination
//   wb_data      in   XLEN       writeback value
//   rf_rd_en1    out  1          register file read enable, port 1
//   rf_rd_en2    out  1          register file read enable, port 2
//   rf_rd_addr1  out  ADDR_W     register file read address, port 1
//   rf_rd_addr2  out  ADDR_W     register file read address, port 2
//   rf_rd_data1  in   XLEN       register file read data, valid the cycle after rf_rd_en1
//   rf_rd_data2  in   XLEN       register file read data, valid the cycle after rf_rd_en2
//   rf_wr_en     out  1          register file write enable
//   rf_wr_addr   out  ADDR_W     register file write address
//   rf_wr_data   out  XLEN       register file write data
//   out_valid    out  1          operands valid
//   out_ready    in   1          consumer ready
//   out_op1      out  XLEN       resolved operand 1
//   out_op2      out  XLEN       resolved operand 2
//   out_payload  out  PAYLOAD_W  sideband
// BEHAVIOUR
// - FSM has three states: IDLE, READ and VALID. Reset enters IDLE.
// - Reset values: out_valid=0, out_op1=0, out_op2=0, out_payload=0, and all registered hazard state = 0.
// - in_ready = (IDLE) | (VALID & out_ready). It is 0 in READ.
// - Accept cycle T (in_valid & in_ready):
//   - rf_rd_enN = in_use_rsN & (in_rsN != 0) and rf_rd_addrN = in_rsN, driven combinationally.
//   - Outside an accept cycle rf_rd_en* = 0 and rf_rd_addr* = 0.
//   - Latch rs1, rs2, use flags and payload. Latch the T writeback (wb_valid, wb_addr, wb_data) into prev_wb.
//   - Next state is READ.
// - READ (cycle T+1): resolve each operand N with this priority:
//   1. Unused or rsN == 0 gives 0.
//   2. wb_valid & wb_addr == rsN (live T+1 writeback) gives wb_data.
//   3. prev_wb valid & addr == rsN (the register file reads before it writes, so T data is stale) gives prev_wb data.
//   4. Otherwise rf_rd_dataN.
//   Register the result into out_op*, then go to VALID.
// - VALID: out_valid=1, with out_op* and out_payload held stable until out_ready.
//   - Writebacks during VALID do NOT update the held operands; the snapshot point is cycle T+1.
//   - out_ready & in_valid: handshake out and accept new in the same cycle, then go to READ.
//   - out_ready & !in_valid: go to IDLE.
// - Latency is accept at T, out_valid at T+2. Peak throughput is 1 request per 2 cycles.
// - Write port is combinational:
//   - rf_wr_en = wb_valid & (wb_addr != 0), rf_wr_addr = wb_addr, rf_wr_data = wb_data.
//   - Writes to x0 are dropped.
//   - The writeback port is never stalled and is independent of FSM state.
// - rs1 == rs2: both operands resolve identically through the same priority.
// - Reset asserted mid-operation: immediately go to IDLE, clear out_valid, and discard the in-flight request.
//   The first accept is possible on the first clock edge after reset deasserts.
// TESTING
// 1. Reset with reset=0 mid-VALID -> out_valid=0 and in_ready=1 with no clock; no rf_rd_en pulse after release until in_valid.
// 2. wb x5=0x1234 and x6=0x55, then later request rs1=5, rs2=6 -> rf_rd_en1/2=1 at T; out_op1=0x1234, out_op2=0x55 at T+2.
// 3. Request rs1=7 with wb x7=0xAAAA in cycle T (same cycle) -> out_op1=0xAAAA (prev_wb forward, not the stale rf data).
// 4. Request rs1=7 with wb x7=0xBBBB at T and wb x7=0xCCCC at T+1 -> out_op1=0xCCCC (live forward wins).
// 5. rs1=0 with wb x0=0xFFFF -> rf_wr_en=0 and rf_rd_en1=0; out_op1=0. in_use_rs2=0 -> out_op2=0.
// 6. Backpressure: out_ready=0 for 3 cycles -> out_* held stable, in_ready=0; then out_ready=1 with in_valid=1 -> new accept in that same cycle.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Bus bundle for operand_fetch: request handshake, writeback port,
// register-file read/write ports and the operand handshake toward the consumer.
//   master : the operand_fetch side (drives in_ready, rf_*, out_*)
//   slave  : the environment side (drives in_*, wb_*, rf_rd_data*, out_ready)
interface operand_fetch_if #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int PAYLOAD_W = 32
);
  localparam int ADDR_W = $clog2(NREG);

  // request side
  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_W-1:0]    in_rs1;
  logic [ADDR_W-1:0]    in_rs2;
  logic                 in_use_rs1;
  logic                 in_use_rs2;
  logic [PAYLOAD_W-1:0] in_payload;

  // writeback stage
  logic                 wb_valid;
  logic [ADDR_W-1:0]    wb_addr;
  logic [XLEN-1:0]      wb_data;

  // register file ports
  logic                 rf_rd_en1;
  logic                 rf_rd_en2;
  logic [ADDR_W-1:0]    rf_rd_addr1;
  logic [ADDR_W-1:0]    rf_rd_addr2;
  logic [XLEN-1:0]      rf_rd_data1;
  logic [XLEN-1:0]      rf_rd_data2;
  logic                 rf_wr_en;
  logic [ADDR_W-1:0]    rf_wr_addr;
  logic [XLEN-1:0]      rf_wr_data;

  // operand side
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_op1;
  logic [XLEN-1:0]      out_op2;
  logic [PAYLOAD_W-1:0] out_payload;

  modport master (
    input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_payload,
    input  wb_valid, wb_addr, wb_data,
    input  rf_rd_data1, rf_rd_data2,
    input  out_ready,
    output in_ready,
    output rf_rd_en1, rf_rd_en2, rf_rd_addr1, rf_rd_addr2,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    output out_valid, out_op1, out_op2, out_payload
  );

  modport slave (
    output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_payload,
    output wb_valid, wb_addr, wb_data,
    output rf_rd_data1, rf_rd_data2,
    output out_ready,
    input  in_ready,
    input  rf_rd_en1, rf_rd_en2, rf_rd_addr1, rf_rd_addr2,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    input  out_valid, out_op1, out_op2, out_payload
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: issues register-file reads for a decoded instruction, forwards
// in-flight writebacks over the stale read data, zeroes x0 / unused operands and
// presents both operands downstream. Also drives the register-file write port
// straight from the writeback stage, dropping writes to x0.
// Ports:
//   clk    clock, all state on posedge
//   reset  asynchronous, active-low reset
//   bus    operand_fetch_if.master: request handshake (in_*), writeback (wb_*),
//          register-file read/write ports (rf_*), operand handshake (out_*)
// Timing: accept at T, reads issued at T, read data and live writeback resolved
// at T+1, operands valid from T+2 until the consumer takes them.
module operand_fetch #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int PAYLOAD_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  operand_fetch_if.master bus
);
  localparam int ADDR_W = $clog2(NREG);
  localparam logic [ADDR_W-1:0] X0 = {ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    rs1_q, rs1_d, rs2_q, rs2_d;
  logic                 use1_q, use1_d, use2_q, use2_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 pwb_valid_q, pwb_valid_d;
  logic [ADDR_W-1:0]    pwb_addr_q, pwb_addr_d;
  logic [XLEN-1:0]      pwb_data_q, pwb_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [XLEN-1:0]      op1_q, op1_d, op2_q, op2_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;

  logic                 in_ready_s;
  logic                 accept_s;
  logic                 rd_en1_s, rd_en2_s;
  logic [ADDR_W-1:0]    rd_addr1_s, rd_addr2_s;

  // Operand priority: zero for x0/unused, then the live writeback, then the
  // writeback captured at accept time (the register file read it too early),
  // then the register-file read data.
  function automatic logic [XLEN-1:0] resolve_op(
    input logic              use_rs,
    input logic [ADDR_W-1:0] rs,
    input logic              live_v,
    input logic [ADDR_W-1:0] live_a,
    input logic [XLEN-1:0]   live_d,
    input logic              prev_v,
    input logic [ADDR_W-1:0] prev_a,
    input logic [XLEN-1:0]   prev_d,
    input logic [XLEN-1:0]   rf_d
  );
    logic [XLEN-1:0] r;
    if (!use_rs || (rs == X0)) begin
      r = {XLEN{1'b0}};
    end else if (live_v && (live_a == rs)) begin
      r = live_d;
    end else if (prev_v && (prev_a == rs)) begin
      r = prev_d;
    end else begin
      r = rf_d;
    end
    return r;
  endfunction

  // Request acceptance and register-file read issue on the accept cycle.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready_s = 1'b1;
      ST_READ:  in_ready_s = 1'b0;
      ST_VALID: in_ready_s = bus.out_ready;
      default:  in_ready_s = 1'b0;
    endcase
    accept_s   = bus.in_valid & in_ready_s;
    rd_en1_s   = 1'b0;
    rd_en2_s   = 1'b0;
    rd_addr1_s = X0;
    rd_addr2_s = X0;
    if (accept_s) begin
      rd_en1_s   = bus.in_use_rs1 & (bus.in_rs1 != X0);
      rd_en2_s   = bus.in_use_rs2 & (bus.in_rs2 != X0);
      rd_addr1_s = bus.in_rs1;
      rd_addr2_s = bus.in_rs2;
    end else begin
      rd_en1_s   = 1'b0;
      rd_en2_s   = 1'b0;
    end
  end

  // Next-state, request capture and operand resolution.
  always_comb begin
    state_d       = state_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    use1_d        = use1_q;
    use2_d        = use2_q;
    payload_d     = payload_q;
    pwb_valid_d   = pwb_valid_q;
    pwb_addr_d    = pwb_addr_q;
    pwb_data_d    = pwb_data_q;
    out_valid_d   = out_valid_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    out_payload_d = out_payload_q;

    if (accept_s) begin
      rs1_d       = bus.in_rs1;
      rs2_d       = bus.in_rs2;
      use1_d      = bus.in_use_rs1;
      use2_d      = bus.in_use_rs2;
      payload_d   = bus.in_payload;
      pwb_valid_d = bus.wb_valid;
      pwb_addr_d  = bus.wb_addr;
      pwb_data_d  = bus.wb_data;
    end else begin
      pwb_valid_d = pwb_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        op1_d = resolve_op(use1_q, rs1_q, bus.wb_valid, bus.wb_addr, bus.wb_data,
                           pwb_valid_q, pwb_addr_q, pwb_data_q, bus.rf_rd_data1);
        op2_d = resolve_op(use2_q, rs2_q, bus.wb_valid, bus.wb_addr, bus.wb_data,
                           pwb_valid_q, pwb_addr_q, pwb_data_q, bus.rf_rd_data2);
        out_payload_d = payload_q;
        out_valid_d   = 1'b1;
        state_d       = ST_VALID;
      end
      ST_VALID: begin
        // operands stay frozen here; later writebacks are not folded in
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (bus.in_valid) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_VALID;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rs1_q         <= X0;
      rs2_q         <= X0;
      use1_q        <= 1'b0;
      use2_q        <= 1'b0;
      payload_q     <= {PAYLOAD_W{1'b0}};
      pwb_valid_q   <= 1'b0;
      pwb_addr_q    <= X0;
      pwb_data_q    <= {XLEN{1'b0}};
      out_valid_q   <= 1'b0;
      op1_q         <= {XLEN{1'b0}};
      op2_q         <= {XLEN{1'b0}};
      out_payload_q <= {PAYLOAD_W{1'b0}};
    end else begin
      state_q       <= state_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      use1_q        <= use1_d;
      use2_q        <= use2_d;
      payload_q     <= payload_d;
      pwb_valid_q   <= pwb_valid_d;
      pwb_addr_q    <= pwb_addr_d;
      pwb_data_q    <= pwb_data_d;
      out_valid_q   <= out_valid_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      out_payload_q <= out_payload_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.rf_rd_en1   = rd_en1_s;
  assign bus.rf_rd_en2   = rd_en2_s;
  assign bus.rf_rd_addr1 = rd_addr1_s;
  assign bus.rf_rd_addr2 = rd_addr2_s;

  // Writeback never stalls; x0 writes are simply not enabled.
  assign bus.rf_wr_en    = bus.wb_valid & (bus.wb_addr != X0);
  assign bus.rf_wr_addr  = bus.wb_addr;
  assign bus.rf_wr_data  = bus.wb_data;

  assign bus.out_valid   = out_valid_q;
  assign bus.out_op1     = op1_q;
  assign bus.out_op2     = op2_q;
  assign bus.out_payload = out_payload_q;
endmodule
